// File: rtl/trellis_frame_encoder.sv
// trellis_frame_encoder: streaming rate-1/2 RSC encoder; every frame starts from state 0.
// Define TRELLIS_ENC_TAIL_EN to append MEMORY tail symbols that drive each frame back to state 0.
module trellis_frame_encoder #(
  parameter int SYMBOLS = 10,
  parameter int MEMORY = 2,
  parameter logic [MEMORY:0] FB_POLY = 3'b111,
  parameter logic [MEMORY:0] FF_POLY = 3'b101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_sym,
  output logic              out_last,
  output logic [MEMORY-1:0] out_state
);
  localparam int CW = $clog2(SYMBOLS + 1);
  typedef enum logic {DATA, TAIL} state_t;
  state_t st_q, st_d;
  logic [MEMORY-1:0] r_q, r_d, r_next, ost_q, ost_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] sym_q, sym_d;
  logic vld_q, vld_d, last_q, last_d;
  logic fb, ffr, u, a, p, free, step, last_sym;
  // r_q holds {r_1..r_M} with r_1 in the MSB, so r_k lives at bit MEMORY-k
  always_comb begin
    fb = 1'b0;
    ffr = 1'b0;
    for (int k = 1; k <= MEMORY; k++) begin
      fb = fb ^ (FB_POLY[k] & r_q[MEMORY-k]);
      ffr = ffr ^ (FF_POLY[k] & r_q[MEMORY-k]);
    end
    u = (st_q == TAIL) ? fb : in_bit;
    a = u ^ fb;
    p = (FF_POLY[0] & a) ^ ffr;
    r_next = MEMORY'({a, r_q} >> 1);
  end
  assign free = !vld_q || out_ready;
  assign in_ready = free && (st_q == DATA);
  assign step = (st_q == DATA) ? (in_valid && in_ready) : free;
  assign last_sym = cnt_q == CW'(SYMBOLS - 1);
  always_comb begin
    st_d = st_q;
    r_d = r_q;
    cnt_d = cnt_q;
    vld_d = vld_q && !out_ready;
    sym_d = sym_q;
    last_d = last_q;
    ost_d = ost_q;
    if (step) begin
      vld_d = 1'b1;
      sym_d = {u, p};
      last_d = last_sym;
      ost_d = r_next;
      cnt_d = last_sym ? '0 : cnt_q + CW'(1);
`ifdef TRELLIS_ENC_TAIL_EN
      r_d = r_next;
      st_d = last_sym ? DATA : (cnt_q == CW'(SYMBOLS - MEMORY - 1)) ? TAIL : st_q;
`else
      r_d = last_sym ? '0 : r_next;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= DATA;
      r_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      sym_q <= '0;
      last_q <= 1'b0;
      ost_q <= '0;
    end else begin
      st_q <= st_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      sym_q <= sym_d;
      last_q <= last_d;
      ost_q <= ost_d;
    end
  end
  assign out_valid = vld_q;
  assign out_sym = sym_q;
  assign out_last = last_q;
  assign out_state = ost_q;
endmodule

// File: tb/tb_trellis_frame_encoder.sv
// tb_trellis_frame_encoder: random/directed frames checked against a queue-based encoder model.
module tb_trellis_frame_encoder;
  localparam int SYMBOLS = 4;
  localparam int MEMORY = 2;
  localparam logic [MEMORY:0] FB = 3'b111;
  localparam logic [MEMORY:0] FF = 3'b101;
`ifdef TRELLIS_ENC_TAIL_EN
  localparam int NDATA = SYMBOLS - MEMORY;
  localparam int TAILN = MEMORY;
`else
  localparam int NDATA = SYMBOLS;
  localparam int TAILN = 0;
`endif
  logic clk = 0, reset = 1, in_valid = 0, in_bit = 0, out_ready = 1;
  logic in_ready, out_valid, out_last;
  logic [1:0] out_sym;
  logic [MEMORY-1:0] out_state;
  int checks = 0, failures = 0, lowcnt = 0, nbits = 0;
  int mr [1:MEMORY];
  logic [MEMORY+2:0] expq [$];
  logic [MEMORY+3:0] held;
  bit stall = 0, bp = 0;

  trellis_frame_encoder #(.SYMBOLS(SYMBOLS), .MEMORY(MEMORY), .FB_POLY(FB), .FF_POLY(FF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_last(out_last),
    .out_state(out_state));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MEMORY+2:0] enc(input int ui, input bit tail, input bit last);
    int fb = 0, a, p, s = 0, u;
    for (int k = 1; k <= MEMORY; k++) fb = fb ^ (FB[k] & mr[k]);
    u = tail ? fb : ui;
    a = u ^ fb;
    p = FF[0] & a;
    for (int k = 1; k <= MEMORY; k++) p = p ^ (FF[k] & mr[k]);
    for (int k = MEMORY; k > 1; k--) mr[k] = mr[k-1];
    mr[1] = a;
    for (int k = 1; k <= MEMORY; k++) s = s * 2 + mr[k];
    return {u[0], p[0], last, s[MEMORY-1:0]};
  endfunction

  task automatic model_clear();
    expq.delete();
    nbits = 0;
    for (int k = 1; k <= MEMORY; k++) mr[k] = 0;
  endtask

  task automatic model_in(input logic b);
    nbits++;
    expq.push_back(enc(int'(b), 0, (nbits == NDATA) && (TAILN == 0)));
    if (nbits == NDATA) begin
      for (int t = 0; t < TAILN; t++) expq.push_back(enc(0, 1, t == TAILN - 1));
      for (int k = 1; k <= MEMORY; k++) mr[k] = 0;
      nbits = 0;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      model_clear();
      stall = 0;
    end else begin
      if (stall) check("hold", {out_valid, out_sym, out_last, out_state}, held);
      if (in_valid && in_ready) model_in(in_bit);
      if (out_valid && out_ready)
        check("sym", {out_sym, out_last, out_state}, expq.size() > 0 ? expq.pop_front() : 'x);
      stall = out_valid && !out_ready;
      held = {out_valid, out_sym, out_last, out_state};
      if (!in_ready) lowcnt++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic b, input int gap);
    logic h;
    int n = 0;
    in_valid = 1;
    in_bit = b;
    do begin
      @(negedge clk);
      h = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!h && n < 100);
    check("accept", h, 1);
    in_valid = 0;
    in_bit = 1'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic directed();
    send(1, 0);
    send(0, 0);
    for (int i = 2; i < NDATA; i++) send(0, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 500) begin @(posedge clk); #1; n++; end
    check("drain", expq.size(), 0);
  endtask

  initial begin
    int lc0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sym", out_sym, 0);
    check("rst_last", out_last, 0);
    check("rst_state", out_state, 0);
    check("rst_ready", in_ready, 1);
    reset = 0;
    lc0 = lowcnt;
    directed();
    repeat (3) for (int i = 0; i < NDATA; i++) send(0, 0);
    drain();
    check("tail_stall", lowcnt - lc0, 4 * TAILN);
    bp = 1;
    repeat (3) directed();
    repeat (20) for (int i = 0; i < NDATA; i++) send(1'($urandom), $urandom_range(0, 2));
    drain();
    bp = 0;
    @(posedge clk);
    #1;
    send(1, 0);
    reset = 1;
    @(posedge clk);
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_state", out_state, 0);
    check("abort_last", out_last, 0);
    reset = 0;
    directed();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
